// File: rtl/pipelined_rca_if.sv
// Handshake and data bundle for pipelined_rca. The ovf signal exists only when RCA_OVF_EN is defined.
// Valid/ready: a beat moves on a rising clk edge where valid && ready. Valid is never gated by ready.
// in_ready may fall combinationally with out_ready. Data is held stable while valid && !ready.
interface pipelined_rca_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef RCA_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract: WIDTH-bit carry chain cut into STAGES registered slices.
// Optional signed-overflow output is enabled by defining RCA_OVF_EN. WIDTH must be a multiple of STAGES.
module pipelined_rca #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst,
    pipelined_rca_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // Index g is the data entering slice g; index STAGES is the output register.
    logic [WIDTH-1:0] op_a  [STAGES];
    logic [WIDTH-1:0] op_b  [STAGES];
    logic [WIDTH-1:0] part  [STAGES+1];
    logic             carry [STAGES+1];
    logic             valid [STAGES+1];
    logic             adv;
`ifdef RCA_OVF_EN
    logic             ovf_w;
`endif

    // The whole pipe moves together, so a stalled output freezes every stage.
    assign adv          = !valid[STAGES] || bus.out_ready;
    assign bus.in_ready = adv;

    assign op_a[0]  = bus.a;
    assign op_b[0]  = bus.b ^ {WIDTH{bus.sub}};
    assign part[0]  = '0;
    assign carry[0] = bus.cin ^ bus.sub;
    assign valid[0] = bus.in_valid;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int LO = g * SW;
        localparam int HI = LO + SW;

        logic [SW:0]   c;
        logic [SW-1:0] s;
        logic          valid_q, valid_d;
        logic          carry_q, carry_d;
        logic [HI-1:0] part_q, part_d;

        always_comb begin
            c    = '0;
            s    = '0;
            c[0] = carry[g];
            for (int i = 0; i < SW; i++) begin
                {c[i+1], s[i]} = full_adder(op_a[g][LO+i], op_b[g][LO+i], c[i]);
            end
            valid_d = valid_q;
            carry_d = carry_q;
            part_d  = part_q;
            if (adv) begin
                valid_d         = valid[g];
                carry_d         = c[SW];
                part_d          = part[g][HI-1:0];
                part_d[HI-1:LO] = s;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                part_q  <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                part_q  <= part_d;
            end
        end

        assign valid[g+1] = valid_q;
        assign carry[g+1] = carry_q;
        assign part[g+1]  = WIDTH'(part_q);

        // Operand bits not yet consumed ride alongside to the slice that needs them.
        if (g < STAGES - 1) begin : g_skew
            logic [WIDTH-1:HI] a_q, a_d;
            logic [WIDTH-1:HI] b_q, b_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (adv) begin
                    a_d = op_a[g][WIDTH-1:HI];
                    b_d = op_b[g][WIDTH-1:HI];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign op_a[g+1] = {a_q, {HI{1'b0}}};
            assign op_b[g+1] = {b_q, {HI{1'b0}}};
        end

`ifdef RCA_OVF_EN
        // Signed overflow: carry into the MSB differs from carry out of it.
        if (g == STAGES - 1) begin : g_ovf
            logic ovf_q, ovf_d;

            always_comb begin
                ovf_d = ovf_q;
                if (adv) ovf_d = c[SW] ^ c[SW-1];
            end

            always_ff @(posedge clk) begin
                if (rst) ovf_q <= 1'b0;
                else     ovf_q <= ovf_d;
            end

            assign ovf_w = ovf_q;
        end
`endif
    end

    assign bus.out_valid = valid[STAGES];
    assign bus.sum       = part[STAGES];
    assign bus.cout      = carry[STAGES];
`ifdef RCA_OVF_EN
    assign bus.ovf       = ovf_w;
`endif
endmodule

// File: tb/tb_pipelined_rca.sv
// Directed bench for pipelined_rca (WIDTH=32, STAGES=4): reset, latency, carry chain, subtract,
// back-pressure ordering and mid-stream reset. Checks ovf too when RCA_OVF_EN is defined.
module tb_pipelined_rca;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    pipelined_rca_if #(.WIDTH(WIDTH)) bif ();

    pipelined_rca #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.in_valid = 1'b0;
        bif.a        = '0;
        bif.b        = '0;
        bif.cin      = 1'b0;
        bif.sub      = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bif.in_valid  = 1'b1;
        bif.a         = 32'h1234_5678;
        bif.b         = 32'h1111_1111;
        bif.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (bif.out_valid !== 1'b0 || bif.sum !== 32'h0 || bif.cout !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold: got valid=%b sum=%h cout=%b, want valid=0 sum=0 cout=0",
                         bif.out_valid, bif.sum, bif.cout);
            end
`ifdef RCA_OVF_EN
            tests_run++;
            if (bif.ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_ovf: got %b want 0", bif.ovf);
            end
`endif
        end
        idle_inputs();
        rst = 1'b0;
        step();
        tests_run++;
        if (bif.in_ready !== 1'b1 || bif.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want in_ready=1 out_valid=0",
                     bif.in_ready, bif.out_valid);
        end
    endtask

    // Single operation through an empty pipe: accept, latency, result, then drain.
    task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
        int lat;
        bif.a         = a;
        bif.b         = b;
        bif.cin       = cin;
        bif.sub       = sub;
        bif.in_valid  = 1'b1;
        bif.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bif.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_accept: got in_ready=%b want 1", name, bif.in_ready);
        end
        step();
        idle_inputs();
        lat = 1;
        while (bif.out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        tests_run++;
        if (lat != 4) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d cycles want 4", name, lat);
        end
        tests_run++;
        if (bif.sum !== exp_sum || bif.cout !== exp_cout) begin
            tests_failed++;
            $display("FAIL %s_result: got sum=%h cout=%b want sum=%h cout=%b",
                     name, bif.sum, bif.cout, exp_sum, exp_cout);
        end
`ifdef RCA_OVF_EN
        tests_run++;
        if (bif.ovf !== exp_ovf) begin
            tests_failed++;
            $display("FAIL %s_ovf: got %b want %b", name, bif.ovf, exp_ovf);
        end
`endif
        step();
        tests_run++;
        if (bif.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_drain: got out_valid=%b want 0", name, bif.out_valid);
        end
    endtask

    task automatic test_add();
        test_op("add_latency", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        test_op("add_mixed",   32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        test_op("add_msb",     32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        test_op("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    endtask

    task automatic test_carry_chain();
        test_op("chain_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_op("chain_b1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_subtract();
        test_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        test_op("sub_cin", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    endtask

    task automatic test_back_pressure();
        logic [31:0] a_tab   [8];
        logic [31:0] b_tab   [8];
        logic        sub_tab [8];
        logic [32:0] res_tab [8];
        logic [32:0] exp_q[$];
        logic [32:0] e;
        logic [31:0] held;
        int sent;
        int got;
        int cyc;
        int stall_seen;
        a_tab = '{32'h0000_0001, 32'h0000_FFFF, 32'h00FF_00FF, 32'h1000_0000,
                  32'hFFFF_0000, 32'h0000_000A, 32'h0000_0003, 32'hAAAA_AAAA};
        b_tab = '{32'h0000_0001, 32'h0000_0001, 32'h0101_0101, 32'h2000_0000,
                  32'h0001_0000, 32'h0000_0003, 32'h0000_000A, 32'h5555_5555};
        sub_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        res_tab = '{{1'b0, 32'h0000_0002}, {1'b0, 32'h0001_0000}, {1'b0, 32'h0200_0200},
                    {1'b0, 32'h3000_0000}, {1'b1, 32'h0000_0000}, {1'b1, 32'h0000_0007},
                    {1'b0, 32'hFFFF_FFF9}, {1'b0, 32'hFFFF_FFFF}};
        sent       = 0;
        got        = 0;
        cyc        = 0;
        stall_seen = 0;
        held       = '0;
        while (got < 8 && cyc < 60) begin
            bif.out_ready = !(cyc >= 5 && cyc < 10);
            if (sent < 8) begin
                bif.in_valid = 1'b1;
                bif.a        = a_tab[sent];
                bif.b        = b_tab[sent];
                bif.sub      = sub_tab[sent];
                bif.cin      = 1'b0;
            end else begin
                idle_inputs();
            end
            #1;
            if (bif.out_valid === 1'b1 && !bif.out_ready) begin
                stall_seen++;
                tests_run++;
                if (bif.in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_in_ready: got %b want 0 at cycle %0d", bif.in_ready, cyc);
                end
                if (stall_seen == 1) begin
                    held = bif.sum;
                end else begin
                    tests_run++;
                    if (bif.sum !== held) begin
                        tests_failed++;
                        $display("FAIL bp_hold: got sum=%h want %h at cycle %0d", bif.sum, held, cyc);
                    end
                end
            end
            if (bif.out_valid === 1'b1 && bif.out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL bp_extra: got sum=%h with no result outstanding", bif.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({bif.cout, bif.sum} !== e) begin
                        tests_failed++;
                        $display("FAIL bp_order: got %h want %h (result %0d)", {bif.cout, bif.sum}, e, got);
                    end
                    got++;
                end
            end
            if (bif.in_valid && bif.in_ready === 1'b1) begin
                exp_q.push_back(res_tab[sent]);
                sent++;
            end
            step();
            cyc++;
        end
        idle_inputs();
        bif.out_ready = 1'b1;
        tests_run++;
        if (got != 8 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d results (%0d pending) want 8 (0 pending)", got, exp_q.size());
        end
        tests_run++;
        if (stall_seen != 5) begin
            tests_failed++;
            $display("FAIL bp_stall_len: got %0d stalled cycles want 5", stall_seen);
        end
        tests_run++;
        if (bif.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_no_dup: got out_valid=%b want 0 after last result", bif.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.in_valid = 1'b1;
            bif.a        = 32'd100 + 32'(i);
            bif.b        = 32'(i);
            bif.cin      = 1'b0;
            bif.sub      = 1'b0;
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (bif.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_no_stale: got out_valid=%b sum=%h want out_valid=0 (cycle %0d)",
                         bif.out_valid, bif.sum, i);
            end
            step();
        end
        test_op("mid_next", 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        bif.out_ready = 1'b0;
        test_reset();
        test_add();
        test_carry_chain();
        test_subtract();
        test_back_pressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
